// File: rtl/fetch_pair_aligner.sv
// Instruction buffer that compacts fetch-packet slots into a circular queue and
// presents the two oldest entries to the dual decoder. Optional same-cycle bypass: FETCH_ALIGNER_BYPASS_EN.
module fetch_pair_aligner #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_flush,
  input  logic [63:0] ic_pc,
  input  logic [63:0] ic_instr,
  input  logic        ic_bp,
  input  logic        ic_bp_slot,
  input  logic [1:0]  ic_bp_track,
  input  logic [63:0] ic_bt,
  input  logic        ic_page_fault,
  input  logic        ic_valid,
  output logic        ic_ready,
  output logic [63:0] if_dec0_pc,
  output logic [31:0] if_dec0_instr,
  output logic        if_dec0_bp,
  output logic [1:0]  if_dec0_bp_track,
  output logic [63:0] if_dec0_bt,
  output logic        if_dec0_page_fault,
  output logic        if_dec0_valid,
  output logic [63:0] if_dec1_pc,
  output logic [31:0] if_dec1_instr,
  output logic        if_dec1_bp,
  output logic [1:0]  if_dec1_bp_track,
  output logic [63:0] if_dec1_bt,
  output logic        if_dec1_page_fault,
  output logic        if_dec1_valid,
  input  logic        if_dec_ready
);

  localparam int ABITS = $clog2(DEPTH);
  localparam int CW    = ABITS + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        bp;
    logic [1:0]  bp_track;
    logic [63:0] bt;
    logic        page_fault;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           lo_e, hi_e, pkt0, pkt1, out0, out1;
  logic             s0, s1;
  logic [1:0]       pkt_n, push_n, pop_n;
  logic [ABITS-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [CW-1:0]    count, count_next;
  logic             buf_v0, buf_v1, out_v0, out_v1;
  logic             bypass_act, push;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^ic_pc[1:0];

  // Build both slot entries, then compact enabled slots so pkt0 is the lowest address.
  always_comb begin
    s0 = ~ic_pc[2];
    s1 = ~(ic_bp & ~ic_bp_slot & s0);

    lo_e.pc         = {ic_pc[63:3], 3'b000};
    lo_e.instr      = ic_instr[31:0];
    lo_e.bp         = ic_bp & ~ic_bp_slot;
    lo_e.bp_track   = ic_bp_track;
    lo_e.bt         = (ic_bp & ~ic_bp_slot) ? ic_bt : 64'h0;
    lo_e.page_fault = 1'b0;

    hi_e.pc         = {ic_pc[63:3], 3'b100};
    hi_e.instr      = ic_instr[63:32];
    hi_e.bp         = ic_bp & ic_bp_slot;
    hi_e.bp_track   = ic_bp_track;
    hi_e.bt         = (ic_bp & ic_bp_slot) ? ic_bt : 64'h0;
    hi_e.page_fault = 1'b0;

    pkt0  = s0 ? lo_e : hi_e;
    pkt1  = hi_e;
    pkt_n = (s0 & s1) ? 2'd2 : 2'd1;

    // A faulting fetch yields a single marker entry carrying no instruction bits.
    if (ic_page_fault) begin
      pkt0.instr      = 32'h0;
      pkt0.page_fault = 1'b1;
      pkt_n           = 2'd1;
    end
  end

  assign wr_nxt = wr_ptr + ABITS'(1);
  assign rd_nxt = rd_ptr + ABITS'(1);
  assign buf_v0 = (count != '0);
  assign buf_v1 = (count > CW'(1));

  // Readiness uses only the registered count, never the decoder handshake.
  assign ic_ready = (count <= CW'(DEPTH - 2));

`ifdef FETCH_ALIGNER_BYPASS_EN
  assign bypass_act = (count == '0) & ~pipe_flush & ic_valid;
`else
  assign bypass_act = 1'b0;
`endif

  always_comb begin
    out0   = mem[rd_ptr];
    out1   = mem[rd_nxt];
    out_v0 = buf_v0;
    out_v1 = buf_v1;
    if (bypass_act) begin
      out0   = pkt0;
      out1   = pkt1;
      out_v0 = 1'b1;
      out_v1 = (pkt_n == 2'd2);
    end
  end

  assign push       = ic_valid & ic_ready & ~pipe_flush & ~(bypass_act & if_dec_ready);
  assign push_n     = push ? pkt_n : 2'd0;
  assign pop_n      = (if_dec_ready & ~bypass_act) ? ({1'b0, buf_v0} + {1'b0, buf_v1}) : 2'd0;
  assign count_next = count + CW'(push_n) - CW'(pop_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (pipe_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + ABITS'(push_n);
      rd_ptr <= rd_ptr + ABITS'(pop_n);
      count  <= count_next;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pkt0;
      if (pkt_n == 2'd2) mem[wr_nxt] <= pkt1;
    end
  end

  assign if_dec0_pc         = out0.pc;
  assign if_dec0_instr      = out0.instr;
  assign if_dec0_bp         = out0.bp;
  assign if_dec0_bp_track   = out0.bp_track;
  assign if_dec0_bt         = out0.bt;
  assign if_dec0_page_fault = out0.page_fault;
  assign if_dec0_valid      = out_v0;
  assign if_dec1_pc         = out1.pc;
  assign if_dec1_instr      = out1.instr;
  assign if_dec1_bp         = out1.bp;
  assign if_dec1_bp_track   = out1.bp_track;
  assign if_dec1_bt         = out1.bt;
  assign if_dec1_page_fault = out1.page_fault;
  assign if_dec1_valid      = out_v1;

endmodule

// File: tb/tb_fetch_pair_aligner.sv
// Bench for fetch_pair_aligner: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_fetch_pair_aligner;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, pipe_flush;
  logic [63:0] ic_pc, ic_instr, ic_bt;
  logic        ic_bp, ic_bp_slot, ic_page_fault, ic_valid, ic_ready;
  logic [1:0]  ic_bp_track;
  logic [63:0] d0_pc, d1_pc, d0_bt, d1_bt;
  logic [31:0] d0_instr, d1_instr;
  logic        d0_bp, d1_bp, d0_pf, d1_pf, d0_v, d1_v;
  logic [1:0]  d0_trk, d1_trk;
  logic        dec_ready;

  fetch_pair_aligner #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
    .ic_pc(ic_pc), .ic_instr(ic_instr), .ic_bp(ic_bp), .ic_bp_slot(ic_bp_slot),
    .ic_bp_track(ic_bp_track), .ic_bt(ic_bt), .ic_page_fault(ic_page_fault),
    .ic_valid(ic_valid), .ic_ready(ic_ready),
    .if_dec0_pc(d0_pc), .if_dec0_instr(d0_instr), .if_dec0_bp(d0_bp),
    .if_dec0_bp_track(d0_trk), .if_dec0_bt(d0_bt), .if_dec0_page_fault(d0_pf),
    .if_dec0_valid(d0_v),
    .if_dec1_pc(d1_pc), .if_dec1_instr(d1_instr), .if_dec1_bp(d1_bp),
    .if_dec1_bp_track(d1_trk), .if_dec1_bt(d1_bt), .if_dec1_page_fault(d1_pf),
    .if_dec1_valid(d1_v),
    .if_dec_ready(dec_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [63:0] pc;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        bp;
    logic [63:0] bt;
    logic        pf;
    logic        flush;
    logic        rdy;
    logic        e_ready;
    logic        e_v0;
    logic [63:0] e_pc0;
    logic [31:0] e_in0;
    logic        e_bp0;
    logic [63:0] e_bt0;
    logic        e_pf0;
    logic        e_v1;
    logic [63:0] e_pc1;
    logic [31:0] e_in1;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        bp;
    logic [1:0]  trk;
    logic [63:0] bt;
    logic        pf;
  } ment_t;

  int passed = 0;
  int total  = 0;
  ment_t q[$];
  ment_t pk[$];
  vec_t  vecs[25];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
  endtask

  task automatic applyStimulus(input vec_t v);
    ic_valid      = v.vld;
    ic_pc         = v.pc;
    ic_instr      = {v.hi, v.lo};
    ic_bp         = v.bp;
    ic_bp_slot    = 1'b0;
    ic_bp_track   = 2'b00;
    ic_bt         = v.bt;
    ic_page_fault = v.pf;
    pipe_flush    = v.flush;
    dec_ready     = v.rdy;
  endtask

  task automatic idle(input logic rdy);
    ic_valid = 1'b0; ic_pc = 64'h0; ic_instr = 64'h0; ic_bp = 1'b0; ic_bp_slot = 1'b0;
    ic_bp_track = 2'b00; ic_bt = 64'h0; ic_page_fault = 1'b0; pipe_flush = 1'b0; dec_ready = rdy;
  endtask

  // Reference packet decomposition: walk slots upward from the start address,
  // stopping after a predicted-taken branch or a faulting fetch.
  task automatic build_pkt();
    ment_t e;
    pk.delete();
    for (int s = int'(ic_pc[2]); s < 2; s++) begin
      e.pc    = {ic_pc[63:3], 3'b000} + 64'(4 * s);
      e.instr = (s == 1) ? ic_instr[63:32] : ic_instr[31:0];
      e.bp    = ic_bp && (int'(ic_bp_slot) == s);
      e.trk   = ic_bp_track;
      e.bt    = e.bp ? ic_bt : 64'h0;
      e.pf    = 1'b0;
      if (ic_page_fault) begin
        e.instr = 32'h0;
        e.pf    = 1'b1;
      end
      pk.push_back(e);
      if (ic_page_fault || e.bp) break;
    end
  endtask

  task automatic cmp_entry(input string tag, input ment_t e, input logic [63:0] pc,
                           input logic [31:0] instr, input logic bp, input logic [1:0] trk,
                           input logic [63:0] bt, input logic pf);
    checkOutput({tag, "_pc"}, pc, e.pc);
    checkOutput({tag, "_instr"}, 64'(instr), 64'(e.instr));
    checkOutput({tag, "_bp"}, 64'(bp), 64'(e.bp));
    checkOutput({tag, "_trk"}, 64'(trk), 64'(e.trk));
    checkOutput({tag, "_bt"}, bt, e.bt);
    checkOutput({tag, "_pf"}, 64'(pf), 64'(e.pf));
  endtask

  initial begin
    ment_t  x0, x1;
    logic   byp, mready, exp_v1;
    logic [63:0] r;
    int     npop;

    rst_n = 1'b0;
    idle(1'b0);
    #1;
    checkOutput("rst_ready", 64'(ic_ready), 64'd1);
    checkOutput("rst_v0", 64'(d0_v), 64'd0);
    checkOutput("rst_v1", 64'(d1_v), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef FETCH_ALIGNER_BYPASS_EN
    // Fields: vld,pc,lo,hi,bp,bt,pf,flush,rdy | ready,v0,pc0,in0,bp0,bt0,pf0,v1,pc1,in1
    vecs[0]  = '{1'b1,64'h1000,32'h00100093,32'h00208093,1'b0,64'h0,1'b0,1'b0,1'b1, 1'b1,1'b0,64'h0,32'h0,1'b0,64'h0,1'b0,1'b0,64'h0,32'h0};
    vecs[1]  = '{1'b0,64'h0,32'h0,32'h0,1'b0,64'h0,1'b0,1'b0,1'b1, 1'b1,1'b1,64'h1000,32'h00100093,1'b0,64'h0,1'b0,1'b1,64'h1004,32'h00208093};
    vecs[2]  = '{1'b0,64'h0,32'h0,32'h0,1'b0,64'h0,1'b0,1'b0,1'b1, 1'b1,1'b0,64'h0,32'h0,1'b0,64'h0,1'b0,1'b0,64'h0,32'h0};
    vecs[3]  = '{1'b1,64'h1004,32'hBBBB0000,32'hAAAA0001,1'b0,64'h0,1'b0,1'b0,1'b0, 1'b1,1'b0,64'h0,32'h0,1'b0,64'h0,1'b0,1'b0,64'h0,32'h0};
    vecs[4]  = '{1'b1,64'h1008,32'h22220008,32'h1111000C,1'b0,64'h0,1'b0,1'b0,1'b0, 1'b1,1'b1,64'h1004,32'hAAAA0001,1'b0,64'h0,1'b0,1'b0,64'h0,32'h0};
    vecs[5]  = '{1'b0,64'h0,32'h0,32'h0,1'b0,64'h0,1'b0,1'b0,1'b1, 1'b0,1'b1,64'h1004,32'hAAAA0001,1'b0,64'h0,1'b0,1'b1,64'h1008,32'h22220008};
    vecs[6]  = '{1'b0,64'h0,32'h0,32'h0,1'b0,64'h0,1'b0,1'b0,1'b1, 1'b1,1'b1,64'h100C,32'h1111000C,1'b0,64'h0,1'b0,1'b0,64'h0,32'h0};
    vecs[7]  = '{1'b1,64'h2000,32'h44440000,32'h33330004,1'b1,64'h3000,1'b0,1'b0,1'b0, 1'b1,1'b0,64'h0,32'h0,1'b0,64'h0,1'b0,1'b0,64'h0,32'h0};
    vecs[8]  = '{1'b0,64'h0,32'h0,32'h0,1'b0,64'h0,1'b0,1'b0,1'b1, 1'b1,1'b1,64'h2000,32'h44440000,1'b1,64'h3000,1'b0,1'b0,64'h0,32'h0};
    vecs[9]  = '{1'b1,64'h4000,32'h66660000,32'h55550004,1'b0,64'h0,1'b1,1'b0,1'b0, 1'b1,1'b0,64'h0,32'h0,1'b0,64'h0,1'b0,1'b0,64'h0,32'h0};
    vecs[10] = '{1'b0,64'h0,32'h0,32'h0,1'b0,64'h0,1'b0,1'b0,1'b0, 1'b1,1'b1,64'h4000,32'h0,1'b0,64'h0,1'b1,1'b0,64'h0,32'h0};
    vecs[11] = '{1'b0,64'h0,32'h0,32'h0,1'b0,64'h0,1'b0,1'b0,1'b1, 1'b1,1'b1,64'h4000,32'h0,1'b0,64'h0,1'b1,1'b0,64'h0,32'h0};
    vecs[12] = '{1'b1,64'h1000,32'h1000,32'h1004,1'b0,64'h0,1'b0,1'b0,1'b0, 1'b1,1'b0,64'h0,32'h0,1'b0,64'h0,1'b0,1'b0,64'h0,32'h0};
    vecs[13] = '{1'b1,64'h1008,32'h1008,32'h100C,1'b0,64'h0,1'b0,1'b0,1'b0, 1'b1,1'b1,64'h1000,32'h1000,1'b0,64'h0,1'b0,1'b1,64'h1004,32'h1004};
    vecs[14] = '{1'b1,64'h2000,32'h2000,32'h2004,1'b0,64'h0,1'b0,1'b0,1'b0, 1'b0,1'b1,64'h1000,32'h1000,1'b0,64'h0,1'b0,1'b1,64'h1004,32'h1004};
    vecs[15] = '{1'b0,64'h0,32'h0,32'h0,1'b0,64'h0,1'b0,1'b0,1'b0, 1'b0,1'b1,64'h1000,32'h1000,1'b0,64'h0,1'b0,1'b1,64'h1004,32'h1004};
    vecs[16] = '{1'b0,64'h0,32'h0,32'h0,1'b0,64'h0,1'b0,1'b0,1'b1, 1'b0,1'b1,64'h1000,32'h1000,1'b0,64'h0,1'b0,1'b1,64'h1004,32'h1004};
    vecs[17] = '{1'b0,64'h0,32'h0,32'h0,1'b0,64'h0,1'b0,1'b0,1'b1, 1'b1,1'b1,64'h1008,32'h1008,1'b0,64'h0,1'b0,1'b1,64'h100C,32'h100C};
    vecs[18] = '{1'b0,64'h0,32'h0,32'h0,1'b0,64'h0,1'b0,1'b0,1'b1, 1'b1,1'b0,64'h0,32'h0,1'b0,64'h0,1'b0,1'b0,64'h0,32'h0};
    vecs[19] = '{1'b1,64'h1000,32'hA0,32'hA4,1'b0,64'h0,1'b0,1'b0,1'b0, 1'b1,1'b0,64'h0,32'h0,1'b0,64'h0,1'b0,1'b0,64'h0,32'h0};
    vecs[20] = '{1'b1,64'h1004,32'hB0,32'hB4,1'b0,64'h0,1'b0,1'b0,1'b0, 1'b1,1'b1,64'h1000,32'hA0,1'b0,64'h0,1'b0,1'b1,64'h1004,32'hA4};
    vecs[21] = '{1'b0,64'h0,32'h0,32'h0,1'b0,64'h0,1'b0,1'b1,1'b0, 1'b0,1'b1,64'h1000,32'hA0,1'b0,64'h0,1'b0,1'b1,64'h1004,32'hA4};
    vecs[22] = '{1'b0,64'h0,32'h0,32'h0,1'b0,64'h0,1'b0,1'b0,1'b0, 1'b1,1'b0,64'h0,32'h0,1'b0,64'h0,1'b0,1'b0,64'h0,32'h0};
    vecs[23] = '{1'b1,64'h1000,32'hC0,32'hC4,1'b0,64'h0,1'b0,1'b1,1'b1, 1'b1,1'b0,64'h0,32'h0,1'b0,64'h0,1'b0,1'b0,64'h0,32'h0};
    vecs[24] = '{1'b0,64'h0,32'h0,32'h0,1'b0,64'h0,1'b0,1'b0,1'b1, 1'b1,1'b0,64'h0,32'h0,1'b0,64'h0,1'b0,1'b0,64'h0,32'h0};

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_ready", i), 64'(ic_ready), 64'(vecs[i].e_ready));
      checkOutput($sformatf("vec%0d_v0", i), 64'(d0_v), 64'(vecs[i].e_v0));
      checkOutput($sformatf("vec%0d_v1", i), 64'(d1_v), 64'(vecs[i].e_v1));
      if (vecs[i].e_v0) begin
        checkOutput($sformatf("vec%0d_pc0", i), d0_pc, vecs[i].e_pc0);
        checkOutput($sformatf("vec%0d_instr0", i), 64'(d0_instr), 64'(vecs[i].e_in0));
        checkOutput($sformatf("vec%0d_bp0", i), 64'(d0_bp), 64'(vecs[i].e_bp0));
        checkOutput($sformatf("vec%0d_bt0", i), d0_bt, vecs[i].e_bt0);
        checkOutput($sformatf("vec%0d_pf0", i), 64'(d0_pf), 64'(vecs[i].e_pf0));
      end
      if (vecs[i].e_v1) begin
        checkOutput($sformatf("vec%0d_pc1", i), d1_pc, vecs[i].e_pc1);
        checkOutput($sformatf("vec%0d_instr1", i), 64'(d1_instr), 64'(vecs[i].e_in1));
      end
    end
`endif

    // Asynchronous reset in the middle of operation empties the buffer at once.
    @(negedge clk);
    idle(1'b0);
    ic_valid = 1'b1; ic_pc = 64'h6000; ic_instr = {32'h6004, 32'h6000};
    @(negedge clk);
    idle(1'b0);
    #1;
    checkOutput("midrst_pre_v0", 64'(d0_v), 64'd1);
    checkOutput("midrst_pre_pc0", d0_pc, 64'h6000);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_v0", 64'(d0_v), 64'd0);
    checkOutput("midrst_v1", 64'(d1_v), 64'd0);
    checkOutput("midrst_ready", 64'(ic_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency from an empty buffer: same cycle with bypass, otherwise one cycle.
    @(negedge clk);
    idle(1'b1);
    ic_valid = 1'b1; ic_pc = 64'h5000; ic_instr = {32'h5004, 32'h5000};
    #1;
`ifdef FETCH_ALIGNER_BYPASS_EN
    checkOutput("byp_v0", 64'(d0_v), 64'd1);
    checkOutput("byp_pc0", d0_pc, 64'h5000);
    checkOutput("byp_v1", 64'(d1_v), 64'd1);
    checkOutput("byp_pc1", d1_pc, 64'h5004);
    @(negedge clk);
    idle(1'b1);
    #1;
    checkOutput("byp_after_v0", 64'(d0_v), 64'd0);
`else
    checkOutput("lat_same_v0", 64'(d0_v), 64'd0);
    @(negedge clk);
    idle(1'b1);
    #1;
    checkOutput("lat_v0", 64'(d0_v), 64'd1);
    checkOutput("lat_pc0", d0_pc, 64'h5000);
    checkOutput("lat_v1", 64'(d1_v), 64'd1);
    checkOutput("lat_pc1", d1_pc, 64'h5004);
`endif

    // Randomized traffic against the queue model, starting from an empty buffer.
    q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      ic_valid = ($urandom_range(0, 9) < 7);
      r = {$urandom, $urandom};
      r[1:0] = 2'b00;
      ic_pc = r;
      ic_instr = {$urandom, $urandom};
      ic_bp = ($urandom_range(0, 3) == 0);
      ic_bp_slot = 1'($urandom_range(0, 1));
      ic_bp_track = 2'($urandom_range(0, 3));
      ic_bt = {$urandom, $urandom};
      ic_page_fault = ($urandom_range(0, 15) == 0);
      pipe_flush = ($urandom_range(0, 29) == 0);
      dec_ready = ($urandom_range(0, 9) < 6);
      build_pkt();
      #1;
`ifdef FETCH_ALIGNER_BYPASS_EN
      byp = (q.size() == 0) && !pipe_flush && ic_valid;
`else
      byp = 1'b0;
`endif
      mready = ((DEPTH - q.size()) >= 2);
      checkOutput($sformatf("rnd%0d_ready", cyc), 64'(ic_ready), 64'(mready));
      if (byp) begin
        checkOutput($sformatf("rnd%0d_v0", cyc), 64'(d0_v), 64'd1);
        exp_v1 = (pk.size() == 2);
        checkOutput($sformatf("rnd%0d_v1", cyc), 64'(d1_v), 64'(exp_v1));
        x0 = pk[0];
        cmp_entry($sformatf("rnd%0d_d0", cyc), x0, d0_pc, d0_instr, d0_bp, d0_trk, d0_bt, d0_pf);
        if (exp_v1) begin
          x1 = pk[1];
          cmp_entry($sformatf("rnd%0d_d1", cyc), x1, d1_pc, d1_instr, d1_bp, d1_trk, d1_bt, d1_pf);
        end
      end else begin
        checkOutput($sformatf("rnd%0d_v0", cyc), 64'(d0_v), 64'(q.size() >= 1));
        checkOutput($sformatf("rnd%0d_v1", cyc), 64'(d1_v), 64'(q.size() >= 2));
        if (q.size() >= 1) begin
          x0 = q[0];
          cmp_entry($sformatf("rnd%0d_d0", cyc), x0, d0_pc, d0_instr, d0_bp, d0_trk, d0_bt, d0_pf);
        end
        if (q.size() >= 2) begin
          x1 = q[1];
          cmp_entry($sformatf("rnd%0d_d1", cyc), x1, d1_pc, d1_instr, d1_bp, d1_trk, d1_bt, d1_pf);
        end
      end
      if (pipe_flush) begin
        q.delete();
      end else begin
        if (dec_ready && !byp) begin
          npop = (q.size() >= 2) ? 2 : q.size();
          for (int k = 0; k < npop; k++) void'(q.pop_front());
        end
        if (ic_valid && mready && !(byp && dec_ready)) begin
          foreach (pk[k]) q.push_back(pk[k]);
        end
      end
    end

    @(negedge clk);
    idle(1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
